// File: rtl/reg_n_bits.sv
// N-bit load-enabled storage register with synchronous clear and a one-cycle
// "updated" flag so the register bank can track which entries were just written.
module reg_n_bits #(
  parameter int unsigned     N           = 64,
  parameter logic [N-1:0]    RESET_VALUE = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] x,
  input  logic         load,
  input  logic         clear,
  output logic [N-1:0] x_out,
  output logic         updated
);

  // Initializers give the documented pre-reset simulation value; hardware
  // behaviour before the first reset edge is not relied upon.
  logic [N-1:0] r_x   = RESET_VALUE;
  logic         r_upd = 1'b0;

  // Priority: reset, then clear, then load. Clear beats a coincident load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x   <= RESET_VALUE;
      r_upd <= 1'b0;
    end else if (clear) begin
      r_x   <= RESET_VALUE;
      r_upd <= 1'b0;
    end else if (load) begin
      r_x   <= x;
      r_upd <= 1'b1;
    end else begin
      r_upd <= 1'b0;
    end
  end

  assign x_out   = r_x;
  assign updated = r_upd;

endmodule

// File: tb/tb_reg_n_bits.sv
// Scoreboard bench for reg_n_bits: directed vectors push expected results into
// a queue; a monitor pops and compares one entry after every clock edge.
module tb_reg_n_bits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        load  = 1'b0;
  logic [63:0] x     = '0;

  logic [63:0] q64, q64r, qz;
  logic [7:0]  q8;
  logic        q1;
  logic        u64, u64r, u8, u1, uz;

  always #5 clk = ~clk;

  reg_n_bits #(.N(64)) u_r64 (
    .clk(clk), .rst_n(rst_n), .x(x), .load(load), .clear(clear),
    .x_out(q64), .updated(u64));

  reg_n_bits #(.N(64), .RESET_VALUE(64'h1234)) u_r64r (
    .clk(clk), .rst_n(rst_n), .x(x), .load(load), .clear(clear),
    .x_out(q64r), .updated(u64r));

  reg_n_bits #(.N(8)) u_r8 (
    .clk(clk), .rst_n(rst_n), .x(x[7:0]), .load(load), .clear(clear),
    .x_out(q8), .updated(u8));

  reg_n_bits #(.N(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .x(x[0]), .load(load), .clear(clear),
    .x_out(q1), .updated(u1));

  // Bank entry 0: data tied to zero, load tied high.
  reg_n_bits #(.N(64)) u_rz (
    .clk(clk), .rst_n(rst_n), .x(64'h0), .load(1'b1), .clear(clear),
    .x_out(qz), .updated(uz));

  typedef struct {
    int          sel;
    logic [63:0] exp;
    logic        eupd;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic apply(input logic r, input logic c, input logic l,
                       input logic [63:0] xv, input int sel,
                       input logic [63:0] e, input logic eu, input string nm);
    exp_t t;
    @(negedge clk);
    rst_n = r; clear = c; load = l; x = xv;
    t.sel = sel; t.exp = e; t.eupd = eu; t.name = nm;
    exp_q.push_back(t);
  endtask

  // Monitor: one expected entry per edge; entry 0 is also checked every edge.
  initial begin
    exp_t        t;
    logic [63:0] act;
    logic        act_u;
    forever begin
      @(posedge clk);
      #1;
      n_vec++;
      if (qz !== 64'h0) begin
        n_err++;
        $display("FAIL zero_reg: got %h want 0", qz);
      end
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        case (t.sel)
          0:       begin act = q64;           act_u = u64;  end
          1:       begin act = q64r;          act_u = u64r; end
          2:       begin act = {56'h0, q8};   act_u = u8;   end
          3:       begin act = {63'h0, q1};   act_u = u1;   end
          default: begin act = qz;            act_u = uz;   end
        endcase
        n_vec++;
        if (act !== t.exp) begin
          n_err++;
          $display("FAIL %s x_out: got %h want %h", t.name, act, t.exp);
        end
        n_vec++;
        if (act_u !== t.eupd) begin
          n_err++;
          $display("FAIL %s updated: got %b want %b", t.name, act_u, t.eupd);
        end
      end
    end
  end

  initial begin
    logic r, c;
    // Reset held with load high, then release.
    apply(0, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 64'h0, 0, "rst0");
    apply(0, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 64'h0, 0, "rst1");
    apply(1, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 64'hDEAD_BEEF_0123_4567, 1, "rst_rel");
    // Load then hold.
    apply(1, 0, 1, 64'h5, 0, 64'h5, 1, "ld5");
    for (int i = 0; i < 5; i++)
      apply(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h5, 0, "hold");
    // Back-to-back loads.
    apply(1, 0, 1, 64'h1, 0, 64'h1, 1, "b2b1");
    apply(1, 0, 1, 64'h2, 0, 64'h2, 1, "b2b2");
    apply(1, 0, 1, 64'h3, 0, 64'h3, 1, "b2b3");
    apply(1, 0, 0, 64'h9, 0, 64'h3, 0, "b2b_end");
    // Clear beats load.
    apply(1, 0, 1, 64'hAA, 0, 64'hAA, 1, "ldAA");
    apply(1, 1, 1, 64'h55, 0, 64'h0, 0, "clr");
    apply(1, 0, 1, 64'hAA, 1, 64'hAA, 1, "ldAA_rv");
    apply(1, 1, 1, 64'h55, 1, 64'h1234, 0, "clr_rv");
    apply(1, 0, 1, 64'h66, 1, 64'h66, 1, "ld66_rv");
    apply(0, 0, 1, 64'h77, 1, 64'h1234, 0, "rst_mid_rv");
    // Width corners.
    apply(1, 0, 1, 64'hFF, 2, 64'hFF, 1, "w8_ld");
    apply(1, 0, 0, 64'h00, 2, 64'hFF, 0, "w8_hold");
    apply(1, 0, 1, 64'h0, 3, 64'h0, 1, "w1_0");
    apply(1, 0, 1, 64'h1, 3, 64'h1, 1, "w1_1");
    apply(1, 0, 1, 64'h0, 3, 64'h0, 1, "w1_0b");
    apply(1, 0, 1, 64'h1, 3, 64'h1, 1, "w1_1b");
    // Zero register under random reset/clear.
    for (int i = 0; i < 100; i++) begin
      r = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 3) == 0);
      apply(r, c, 1'($urandom), {$urandom, $urandom}, 4, 64'h0, r & ~c, "zero");
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
